// File: rtl/vga_pkg.sv
// Shared VGA raster constants: 640x480@60 Hz default timing and coordinate width.
// Renderers and the timing generator import this so everyone agrees on the geometry.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Inclusive window test on a scan coordinate.
    function automatic logic in_span(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register with a reset value; aligns sync/blank with a
// renderer pipeline of DEPTH pixel ticks. DEPTH=0 is a straight wire.
module vga_sync_delay import vga_pkg::*; #(
    parameter int               WIDTH     = 2,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, scan coordinates, sync pulses (plain and
// pipeline-delayed) and line/frame strobes. All outputs are registered.
module vga_timing_gen import vga_pkg::*; #(
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BP       = VGA_H_BP,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BP       = VGA_V_BP,
    parameter int   CLK_DIV    = 2,
    parameter int   PIPE_DELAY = 1,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_en,
    output logic               vga_clk,
    output logic [COORD_W-1:0] pixelx,
    output logic [COORD_W-1:0] pixely,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               hsync_dly,
    output logic               vsync_dly,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);

    generate
        if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
            $error("vga_timing_gen: H_TOTAL does not fit the coordinate counter");
        end
        if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
            $error("vga_timing_gen: V_TOTAL does not fit the coordinate counter");
        end
        if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_bad_clk_div
            $error("vga_timing_gen: CLK_DIV must be even and at least 2");
        end
        if ((PIPE_DELAY < 0) || (PIPE_DELAY > 7)) begin : g_bad_pipe_delay
            $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
        end
    endgenerate

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_nxt;
    logic               pix_en_nxt;
    logic               vga_clk_nxt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic               hsync_nxt;
    logic               vsync_nxt;
    logic               active_nxt;
    logic               line_nxt;
    logic               frame_nxt;

    // Decodes and strobes look at next-state counts so they land in the same
    // cycle as the coordinates they describe.
    always_comb begin
        div_nxt     = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        pix_en_nxt  = (div_nxt == DIV_LAST);
        vga_clk_nxt = (div_nxt < DIV_HALF);

        x_nxt = pixelx;
        y_nxt = pixely;
        if (pix_en) begin
            if (pixelx == X_LAST) begin
                x_nxt = '0;
                y_nxt = (pixely == Y_LAST) ? '0 : pixely + 1'b1;
            end else begin
                x_nxt = pixelx + 1'b1;
            end
        end

        hsync_nxt  = in_span(x_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_nxt  = in_span(y_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        active_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        line_nxt   = pix_en_nxt && (x_nxt == X_LAST);
        frame_nxt  = line_nxt && (y_nxt == Y_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            vga_clk     <= 1'b1;
            pixelx      <= '0;
            pixely      <= '0;
            active      <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            pix_en      <= pix_en_nxt;
            vga_clk     <= vga_clk_nxt;
            pixelx      <= x_nxt;
            pixely      <= y_nxt;
            active      <= active_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
        end
    end

    // The delay line captures the sync belonging to the pixel being retired,
    // so each stage lags hsync/vsync by exactly one pixel tick.
    vga_sync_delay #(
        .WIDTH     (2),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL ({~SYNC_POL, ~SYNC_POL})
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  ({hsync, vsync}),
        .dout ({hsync_dly, vsync_dly})
    );

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the 640x480@60 Hz VGA raster: a pixel-rate enable, the pixelx/pixely scan coordinates, and the hsync/vsync pulses. It is the source side of the coordinate interface the graphics renderers consume: renderers map pixelx/pixely to colour and blank. The block also delays sync by the renderer pipeline depth so sync stays aligned with colour at the DAC. It provides frame and line strobes for game-state latching.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525
CLK_DIV, 2, clk cycles per pixel; must be even and >= 2
PIPE_DELAY, 1, renderer latency in pixel ticks (0..7) applied to the delayed syncs
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
pix_en  out  1  one-clk pulse per pixel
vga_clk  out  1  registered pixel clock for the DAC
pixelx  out  10  horizontal count 0..H_TOTAL-1
pixely  out  10  vertical count 0..V_TOTAL-1
active  out  1  high when pixelx<H_ACTIVE and pixely<V_ACTIVE
hsync  out  1  hsync aligned to pixelx
vsync  out  1  vsync aligned to pixely
hsync_dly  out  1  hsync delayed PIPE_DELAY pixel ticks
vsync_dly  out  1  vsync delayed PIPE_DELAY pixel ticks
line_start  out  1  one-clk pulse at line wrap
frame_start  out  1  one-clk pulse at frame wrap

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: div_cnt=0, pixelx=0, pixely=0, pix_en=0, line_start=0, frame_start=0, active=1. hsync, vsync, hsync_dly, vsync_dly and every delay stage hold ~SYNC_POL. vga_clk=1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and is high in the clk cycle where div_cnt==CLK_DIV-1.
  - vga_clk is registered: high while div_cnt<CLK_DIV/2, otherwise low.
- Counters advance only on pix_en cycles:
  - pixelx wraps from H_TOTAL-1 to 0; pixely increments on that wrap.
  - pixely wraps from V_TOTAL-1 to 0.
  - Between pix_en pulses, all counters and decodes hold.
- Decodes (hsync, vsync, active) are registered and computed from the next-state counts, so they are valid in the same cycle as the matching pixelx/pixely and never glitch.
  - hsync = SYNC_POL when pixelx is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync = SYNC_POL when pixely is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- line_start = pix_en & (pixelx==H_TOTAL-1).
- frame_start = pix_en & (pixelx==H_TOTAL-1) & (pixely==V_TOTAL-1). It is a subset of line_start, asserted together with it.
- No frame_start is issued for the implicit frame start at reset release. The first frame_start comes at the end of the first frame.
- Delay line:
  - PIPE_DELAY-stage shift register of {hsync, vsync}, shifted only on pix_en.
  - PIPE_DELAY=0 makes hsync_dly/vsync_dly equal to hsync/vsync.
- Latency:
  - Line = 800 pixel ticks = 1600 clk cycles.
  - Frame = 420000 pixel ticks = 840000 clk cycles at CLK_DIV=2.
- Reset mid-frame: on the next clk edge all state returns to reset values. Any sync pulse in progress is truncated. No strobe fires in the reset cycle.
- Width rule: counters are 10 bits. Elaboration must fail if H_TOTAL or V_TOTAL exceeds 1024.

Decomposition:
- Shared package vga_pkg holds the timing constants (H_*/V_* defaults), the derived H_TOTAL, V_TOTAL and sync start/end values, and COORD_W=10.
- One natural sub-module, vga_sync_delay: a parameterised-depth shift register with an enable and a reset value. It is reused by renderers for blank alignment.

Test Plan:
1. Hold rst 3 cycles -> pixelx=0, pixely=0, pix_en=0, hsync=vsync=1, strobes 0. Release rst -> pix_en first high 2 clk later, then every 2nd clk.
2. Run one line -> pixelx steps 0..799 once per pix_en, then 799->0 with pixely 0->1. line_start high exactly once, in the cycle where pixelx=799 and pix_en=1.
3. hsync check -> low for exactly 96 pix_en ticks, first low at pixelx=656, high again at pixelx=752. active=0 for pixelx>=640.
4. vsync check -> low only for pixely 490..491. frame_start pulses exactly 840000 clk apart, each at pixelx=799, pixely=524.
5. Mid-frame reset: assert rst at pixelx=300, pixely=200 for 1 cycle -> next cycle pixelx=0, pixely=0, syncs=1, no frame_start. Counting resumes normally.
6. PIPE_DELAY=2 -> hsync_dly first low at pixelx=658 and high at 754. With PIPE_DELAY=0 -> hsync_dly equals hsync on every cycle.
